// File: rtl/timer_pkg.sv
// Shared definitions for the timer IP: register map, TCR field layout,
// divider limit and the APB front-end state encoding.
package timer_pkg;

   localparam logic [11:0] TCR_OFF   = 12'h000;
   localparam logic [11:0] TDR0_OFF  = 12'h004;
   localparam logic [11:0] TDR1_OFF  = 12'h008;
   localparam logic [11:0] TCMP0_OFF = 12'h00C;
   localparam logic [11:0] TCMP1_OFF = 12'h010;
   localparam logic [11:0] TIER_OFF  = 12'h014;
   localparam logic [11:0] TISR_OFF  = 12'h018;
   localparam logic [11:0] THCSR_OFF = 12'h01C;

   // TCR layout: bit0 timer_en, bit1 div_en, bits 11:8 div_val
   localparam int TCR_EN_BIT     = 0;
   localparam int TCR_DIV_EN_BIT = 1;
   localparam int TCR_DIV_LSB    = 8;
   localparam int TCR_DIV_MSB    = 11;
   localparam int TCR_DIV_MAX    = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

endpackage

// File: rtl/timer_apb_err_chk.sv
// Combinational legality decode for one APB transfer: unmapped/misaligned
// address, and TCR writes that are illegal against the live TCR value.
module timer_apb_err_chk
   import timer_pkg::*;
#(
   parameter int                ADDR_W       = 12,
   parameter int                DATA_W       = 32,
   parameter logic [ADDR_W-1:0] REG_MAX_ADDR = ADDR_W'(THCSR_OFF),
   parameter int                DIV_MAX      = TCR_DIV_MAX
) (
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   input  logic [3:0]        pstrb,
   input  logic              pwrite,
   input  logic [31:0]       tcr,
   output logic              err_addr,
   output logic              err_tcr
);

   localparam logic [ADDR_W-1:0] TCR_ADDR = ADDR_W'(TCR_OFF);

   logic [3:0] div_new;
   logic [3:0] div_cur;
   logic       is_tcr_wr;
   logic       div_over;
   logic       en_chg;
   logic       div_chg;
   logic       unused_bits;

   assign div_new = pwdata[TCR_DIV_MSB:TCR_DIV_LSB];
   assign div_cur = tcr[TCR_DIV_MSB:TCR_DIV_LSB];

   assign err_addr = (paddr[1:0] != 2'b00) || (paddr > REG_MAX_ADDR);

   assign is_tcr_wr = pwrite && (paddr == TCR_ADDR);
   assign div_over  = pstrb[1] && (div_new > 4'(DIV_MAX));

   // While the timer runs, only rewriting the current div_en/div_val is allowed
   assign en_chg  = pstrb[0] && (pwdata[TCR_DIV_EN_BIT] != tcr[TCR_DIV_EN_BIT]);
   assign div_chg = pstrb[1] && (div_new != div_cur);

   assign err_tcr = is_tcr_wr && (div_over || (tcr[TCR_EN_BIT] && (en_chg || div_chg)));

   assign unused_bits = ^{pwdata[DATA_W-1:12], pwdata[7:2], pwdata[0],
                          tcr[31:12], tcr[7:2], pstrb[3:2]};

endmodule

// File: rtl/timer_apb_if.sv
// APB slave front-end for the timer register block: turns setup/access phases
// into single-cycle wr_en/rd_en strobes and returns rdata/pready/pslverr.
module timer_apb_if
   import timer_pkg::*;
#(
   parameter int                ADDR_W       = 12,
   parameter int                DATA_W       = 32,
   parameter logic [ADDR_W-1:0] REG_MAX_ADDR = ADDR_W'(THCSR_OFF),
   parameter int                DIV_MAX      = TCR_DIV_MAX,
   parameter int                TIMEOUT      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   input  logic [3:0]        pstrb,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              wr_en,
   output logic              rd_en,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   output logic [3:0]        wstrb,
   output logic              pslverr_o,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic              pready_w_i,
   input  logic [31:0]       tcr_i
);

   // Handshake: a transfer starts on psel=1/penable=0 (setup); the bus then
   // holds psel/penable high until pready. The register block sees exactly one
   // wr_en/rd_en per transfer and answers with pready_w_i one cycle later.

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   apb_state_e        state;
   apb_state_e        state_nxt;
   logic [CNT_W-1:0]  wait_cnt;

   logic              lat_write;
   logic              lat_err_addr;
   logic              lat_err_tcr;
   logic              chk_err_addr;
   logic              chk_err_tcr;

   logic              setup;
   logic              latch_en;
   logic              wr_en_nxt;
   logic              rd_en_nxt;
   logic              pso_nxt;
   logic              resp_nxt;
   logic              resp_err_nxt;
   logic [DATA_W-1:0] resp_data_nxt;
   logic              cnt_clr;
   logic              cnt_inc;

   timer_apb_err_chk #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .REG_MAX_ADDR (REG_MAX_ADDR),
      .DIV_MAX      (DIV_MAX)
   ) u_err_chk (
      .paddr    (paddr),
      .pwdata   (pwdata),
      .pstrb    (pstrb),
      .pwrite   (pwrite),
      .tcr      (tcr_i),
      .err_addr (chk_err_addr),
      .err_tcr  (chk_err_tcr)
   );

   assign setup = psel && !penable;

   always_comb begin
      state_nxt     = state;
      latch_en      = 1'b0;
      wr_en_nxt     = 1'b0;
      rd_en_nxt     = 1'b0;
      pso_nxt       = 1'b0;
      resp_nxt      = 1'b0;
      resp_err_nxt  = 1'b0;
      resp_data_nxt = '0;
      cnt_clr       = 1'b0;
      cnt_inc       = 1'b0;

      case (state)
         ST_IDLE: begin
            if (setup) latch_en = 1'b1;
         end
         ST_ACCESS: begin
            if (!psel) begin
               state_nxt = ST_IDLE;
            end else if (lat_err_addr) begin
               state_nxt    = ST_RESP;
               resp_nxt     = 1'b1;
               resp_err_nxt = 1'b1;
            end else begin
               state_nxt = ST_WAIT;
               cnt_clr   = 1'b1;
            end
         end
         ST_WAIT: begin
            if (!psel) begin
               state_nxt = ST_IDLE;
            end else if (pready_w_i) begin
               state_nxt     = ST_RESP;
               resp_nxt      = 1'b1;
               resp_err_nxt  = lat_err_tcr;
               resp_data_nxt = lat_write ? '0 : rdata_i;
            end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
               state_nxt    = ST_RESP;
               resp_nxt     = 1'b1;
               resp_err_nxt = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_RESP: begin
            state_nxt = ST_IDLE;
            if (setup) latch_en = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase

      // Strobes are registered so they are high exactly while in ACCESS
      if (latch_en) begin
         state_nxt = ST_ACCESS;
         wr_en_nxt = pwrite && !chk_err_addr;
         rd_en_nxt = !pwrite && !chk_err_addr;
         pso_nxt   = pwrite && !chk_err_addr && chk_err_tcr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         wait_cnt     <= '0;
         lat_write    <= 1'b0;
         lat_err_addr <= 1'b0;
         lat_err_tcr  <= 1'b0;
         addr         <= '0;
         wdata        <= '0;
         wstrb        <= '0;
         wr_en        <= 1'b0;
         rd_en        <= 1'b0;
         pslverr_o    <= 1'b0;
         pready       <= 1'b0;
         pslverr      <= 1'b0;
         prdata       <= '0;
      end else begin
         state     <= state_nxt;
         wr_en     <= wr_en_nxt;
         rd_en     <= rd_en_nxt;
         pslverr_o <= pso_nxt;
         pready    <= resp_nxt;
         pslverr   <= resp_err_nxt;
         prdata    <= resp_data_nxt;

         if (cnt_clr)      wait_cnt <= '0;
         else if (cnt_inc) wait_cnt <= wait_cnt + CNT_W'(1);

         if (latch_en) begin
            addr         <= paddr;
            wdata        <= pwdata;
            wstrb        <= pstrb;
            lat_write    <= pwrite;
            lat_err_addr <= chk_err_addr;
            lat_err_tcr  <= chk_err_tcr;
         end
      end
   end

   a_one_strobe: assert property (@(posedge clk) disable iff (rst) !(wr_en && rd_en));
   a_pso_with_wr: assert property (@(posedge clk) disable iff (rst) !(pslverr_o && !wr_en));
   a_ready_in_resp: assert property (@(posedge clk) disable iff (rst) pready == (state == ST_RESP));
   a_quiet_bus: assert property (@(posedge clk) disable iff (rst)
      !pready |-> (!pslverr && (prdata == '0)));

endmodule

// File: tb/tb_timer_apb_if.sv
// Directed bench for timer_apb_if: APB master driver tasks, a register-block
// responder, a bus monitor and one task per feature with inline checks.
module tb_timer_apb_if;
  import timer_pkg::*;

  logic        clk, rst;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        wr_en, rd_en;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        pslverr_o;
  logic [31:0] rdata_i;
  logic        pready_w_i;
  logic [31:0] tcr_i;

  int vectors = 0;
  int errors  = 0;

  // register-block model controls
  logic        rb_en;
  logic [31:0] rb_rdata;
  logic        strobe_seen;

  // monitor captures
  int          n_wr, n_rd, n_rdy, n_leak;
  logic        pso_at, err_at;
  logic [11:0] addr_at;
  logic [31:0] wdata_at, rdata_at;
  logic [3:0]  wstrb_at;

  timer_apb_if dut (
    .clk        (clk),
    .rst        (rst),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .addr       (addr),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .pslverr_o  (pslverr_o),
    .rdata_i    (rdata_i),
    .pready_w_i (pready_w_i),
    .tcr_i      (tcr_i)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got no completion, required finish before 100000 time units");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- register block responder ----------------
  // Answers a strobe one cycle later; rdata_i carries a decoy value otherwise.
  initial begin
    pready_w_i = 1'b0;
    rdata_i    = 32'h1234_5678;
    forever begin
      @(posedge clk);
      strobe_seen = wr_en || rd_en;
      #1;
      pready_w_i = rb_en && strobe_seen;
      rdata_i    = (rb_en && strobe_seen) ? rb_rdata : 32'h1234_5678;
    end
  end

  // ---------------- bus monitor ----------------
  initial begin
    n_leak = 0;
    forever begin
      @(negedge clk);
      if (wr_en) n_wr++;
      if (rd_en) n_rd++;
      if (wr_en || rd_en) begin
        pso_at   = pslverr_o;
        addr_at  = addr;
        wdata_at = wdata;
        wstrb_at = wstrb;
      end
      if (pready) begin
        n_rdy++;
        rdata_at = prdata;
        err_at   = pslverr;
      end
      if (!pready && (pslverr || prdata !== 32'h0)) n_leak++;
      if (pslverr_o && !wr_en) n_leak++;
      if (wr_en && rd_en) n_leak++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 12'h0;
    pwdata  = 32'h0;
    pstrb   = 4'h0;
  endtask

  task automatic clr_mon();
    n_wr     = 0;
    n_rd     = 0;
    n_rdy    = 0;
    pso_at   = 1'b0;
    err_at   = 1'b0;
    addr_at  = 12'hFFF;
    wdata_at = 32'hDEAD_DEAD;
    wstrb_at = 4'h0;
    rdata_at = 32'hDEAD_DEAD;
  endtask

  task automatic drive_setup(input logic wr, input logic [11:0] a,
                             input logic [31:0] d, input logic [3:0] s);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    pstrb   = s;
  endtask

  // Full transfer; lat = cycles from setup cycle to the pready cycle, -1 on timeout
  task automatic xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int lat);
    @(posedge clk); #1;
    clr_mon();
    drive_setup(wr, a, d, s);
    @(posedge clk); #1;
    penable = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (pready) begin
        lat = k;
        break;
      end
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if ({wr_en, rd_en, pready, pslverr, pslverr_o} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b required 00000", {wr_en, rd_en, pready, pslverr, pslverr_o}); end
    vectors++; if (prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h required 0", prdata); end
    vectors++; if ({addr, wdata, wstrb} !== 48'h0) begin errors++; $display("FAIL reset_latches: got %h/%h/%h required 0", addr, wdata, wstrb); end
    // reset on the setup edge: nothing latched, no strobe, later access phase ignored
    @(posedge clk); #1;
    clr_mon();
    drive_setup(1'b1, TDR0_OFF, 32'h0000_00AB, 4'hF);
    @(posedge clk); #1;
    rst = 1'b0;
    penable = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    vectors++; if (n_wr + n_rd !== 0) begin errors++; $display("FAIL reset_mid_strobe: got %0d strobes required 0", n_wr + n_rd); end
    vectors++; if (n_rdy !== 0) begin errors++; $display("FAIL reset_mid_pready: got %0d ready cycles required 0", n_rdy); end
    vectors++; if (addr !== 12'h0) begin errors++; $display("FAIL reset_mid_addr: got %h required 000", addr); end
    @(posedge clk); #1;
    drive_idle();
    n_leak = 0;
  endtask

  task automatic test_write_tcr();
    int lat;
    tcr_i = 32'h0000_0100;
    rb_en = 1'b1;
    xfer(1'b1, TCR_OFF, 32'h0000_0103, 4'h3, lat);
    vectors++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d required 3", lat); end
    vectors++; if (n_wr !== 1 || n_rd !== 0) begin errors++; $display("FAIL wr_strobes: got wr=%0d rd=%0d required wr=1 rd=0", n_wr, n_rd); end
    vectors++; if ({addr_at, wdata_at, wstrb_at} !== {12'h000, 32'h0000_0103, 4'h3}) begin errors++; $display("FAIL wr_payload: got %h/%h/%h required 000/00000103/3", addr_at, wdata_at, wstrb_at); end
    vectors++; if (pso_at !== 1'b0) begin errors++; $display("FAIL wr_pslverr_o: got %b required 0", pso_at); end
    vectors++; if (err_at !== 1'b0 || rdata_at !== 32'h0) begin errors++; $display("FAIL wr_resp: got err=%b prdata=%h required err=0 prdata=0", err_at, rdata_at); end
  endtask

  task automatic test_read();
    int lat;
    rb_en = 1'b1;
    rb_rdata = 32'hFFFF_FFFF;
    xfer(1'b0, TCMP0_OFF, 32'h0, 4'h0, lat);
    vectors++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d required 3", lat); end
    vectors++; if (n_rd !== 1 || n_wr !== 0) begin errors++; $display("FAIL rd_strobes: got wr=%0d rd=%0d required wr=0 rd=1", n_wr, n_rd); end
    vectors++; if (addr_at !== 12'h00C) begin errors++; $display("FAIL rd_addr: got %h required 00C", addr_at); end
    vectors++; if (rdata_at !== 32'hFFFF_FFFF || err_at !== 1'b0) begin errors++; $display("FAIL rd_resp: got prdata=%h err=%b required FFFFFFFF/0", rdata_at, err_at); end
    rb_rdata = 32'hC0DE_0042;
    xfer(1'b0, THCSR_OFF, 32'h0, 4'h0, lat);
    vectors++; if (lat !== 3 || n_rd !== 1) begin errors++; $display("FAIL rd_top_reg: got lat=%0d rd=%0d required 3/1", lat, n_rd); end
    vectors++; if (rdata_at !== 32'hC0DE_0042 || err_at !== 1'b0) begin errors++; $display("FAIL rd_top_resp: got prdata=%h err=%b required C0DE0042/0", rdata_at, err_at); end
  endtask

  task automatic test_tcr_rules();
    logic [11:0] t_addr [8] = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h004, 12'h000};
    logic [31:0] t_data [8] = '{32'h900, 32'h203, 32'h800, 32'h101, 32'h002, 32'h203, 32'h900, 32'hF03};
    logic [3:0]  t_strb [8] = '{4'h2,    4'h3,    4'h2,    4'h3,    4'h1,    4'h4,    4'h2,    4'h1};
    logic [31:0] t_tcr  [8] = '{32'h100, 32'h101, 32'h000, 32'h101, 32'h101, 32'h101, 32'h000, 32'h000};
    logic        t_err  [8] = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b1,    1'b0,    1'b0,    1'b0};
    int lat;
    rb_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tcr_i = t_tcr[i];
      xfer(1'b1, t_addr[i], t_data[i], t_strb[i], lat);
      vectors++; if (lat !== 3 || n_wr !== 1) begin errors++; $display("FAIL tcr_rule%0d_flow: got lat=%0d wr=%0d required 3/1", i, lat, n_wr); end
      vectors++; if (pso_at !== t_err[i]) begin errors++; $display("FAIL tcr_rule%0d_pslverr_o: got %b required %b", i, pso_at, t_err[i]); end
      vectors++; if (err_at !== t_err[i]) begin errors++; $display("FAIL tcr_rule%0d_pslverr: got %b required %b", i, err_at, t_err[i]); end
    end
    tcr_i = 32'h0;
  endtask

  task automatic test_illegal_addr();
    logic [11:0] bad [2] = '{12'h020, 12'h006};
    int lat;
    rb_en = 1'b1;
    rb_rdata = 32'hAAAA_5555;
    for (int i = 0; i < 2; i++) begin
      xfer(1'b0, bad[i], 32'h0, 4'h0, lat);
      vectors++; if (lat !== 2) begin errors++; $display("FAIL bad_addr%0d_latency: got %0d required 2", i, lat); end
      vectors++; if (n_rd + n_wr !== 0) begin errors++; $display("FAIL bad_addr%0d_strobe: got %0d required 0", i, n_rd + n_wr); end
      vectors++; if (err_at !== 1'b1 || rdata_at !== 32'h0) begin errors++; $display("FAIL bad_addr%0d_resp: got err=%b prdata=%h required 1/0", i, err_at, rdata_at); end
    end
  endtask

  task automatic test_abort();
    int lat;
    rb_en = 1'b1;
    rb_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    clr_mon();
    drive_setup(1'b0, TDR0_OFF, 32'h0, 4'h0);
    @(posedge clk); #1;
    drive_idle();
    repeat (6) @(posedge clk);
    @(negedge clk);
    vectors++; if (n_rd !== 1) begin errors++; $display("FAIL abort_strobe: got %0d required 1", n_rd); end
    vectors++; if (n_rdy !== 0) begin errors++; $display("FAIL abort_pready: got %0d ready cycles required 0", n_rdy); end
    rb_rdata = 32'h0BAD_CAFE;
    xfer(1'b0, TDR1_OFF, 32'h0, 4'h0, lat);
    vectors++; if (lat !== 3 || rdata_at !== 32'h0BAD_CAFE) begin errors++; $display("FAIL abort_recover: got lat=%0d prdata=%h required 3/0BADCAFE", lat, rdata_at); end
  endtask

  task automatic test_timeout_back_to_back();
    int early;
    int lat;
    rb_en = 1'b0;
    tcr_i = 32'h0;
    @(posedge clk); #1;
    clr_mon();
    drive_setup(1'b1, TIER_OFF, 32'h0000_0001, 4'hF);
    @(posedge clk); #1;
    penable = 1'b1;
    early = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (pready) early++;
    end
    vectors++; if (early !== 0) begin errors++; $display("FAIL timeout_early: got %0d ready cycles required 0", early); end
    // setup of the next read overlaps the RESP cycle
    @(posedge clk); #1;
    rb_en = 1'b1;
    rb_rdata = 32'h0000_5A5A;
    drive_setup(1'b0, TDR0_OFF, 32'h0, 4'h0);
    @(negedge clk);
    vectors++; if (pready !== 1'b1 || pslverr !== 1'b1) begin errors++; $display("FAIL timeout_resp: got pready=%b pslverr=%b required 1/1", pready, pslverr); end
    vectors++; if (prdata !== 32'h0) begin errors++; $display("FAIL timeout_prdata: got %h required 0", prdata); end
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    vectors++; if (rd_en !== 1'b1 || addr !== 12'h004) begin errors++; $display("FAIL b2b_strobe: got rd_en=%b addr=%h required 1/004", rd_en, addr); end
    lat = -1;
    for (int k = 8; k <= 20; k++) begin
      @(negedge clk);
      if (pready) begin
        lat = k;
        break;
      end
    end
    vectors++; if (lat !== 9) begin errors++; $display("FAIL b2b_latency: got %0d required 9", lat); end
    vectors++; if (prdata !== 32'h0000_5A5A || pslverr !== 1'b0) begin errors++; $display("FAIL b2b_resp: got prdata=%h pslverr=%b required 00005A5A/0", prdata, pslverr); end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    vectors++; if (n_wr !== 1 || n_rd !== 1) begin errors++; $display("FAIL b2b_counts: got wr=%0d rd=%0d required 1/1", n_wr, n_rd); end
  endtask

  task automatic test_bus_quiet();
    vectors++; if (n_leak !== 0) begin errors++; $display("FAIL bus_quiet: got %0d bad cycles required 0", n_leak); end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    tcr_i = 32'h0;
    rb_en = 1'b1;
    rb_rdata = 32'h0;
    clr_mon();
    test_reset();
    test_write_tcr();
    test_read();
    test_tcr_rules();
    test_illegal_addr();
    test_abort();
    test_timeout_back_to_back();
    test_bus_quiet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
